// File: rtl/stv_io_arb.sv
// Round-robin arbiter sharing one strobed I/O register bus between the main CPU
// (requester 0) and the host port (requester 1); one access in flight at a time.
module stv_io_arb #(
    parameter int STROBE_CYC  = 2,
    parameter int RECOVER_CYC = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CE,
    input  logic       R0_REQ,
    input  logic [5:0] R0_A,
    input  logic       R0_WE,
    input  logic [7:0] R0_WD,
    output logic       R0_ACK,
    output logic [7:0] R0_RD,
    input  logic       R1_REQ,
    input  logic [5:0] R1_A,
    input  logic       R1_WE,
    input  logic [7:0] R1_WD,
    output logic       R1_ACK,
    output logic [7:0] R1_RD,
    output logic [5:0] IO_A,
    output logic [7:0] IO_DO,
    input  logic [7:0] IO_DI,
    output logic       IO_CS_N,
    output logic       IO_RW_N
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

    localparam logic [3:0] STROBE_LOAD  = 4'(STROBE_CYC - 1);
    localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYC - 1);

    state_t     r_state, w_state_next;
    logic [3:0] r_cnt, w_cnt_next;
    logic       r_gnt;  // granted requester of the current/most recent access
    logic       r_we;
    logic [5:0] r_a;
    logic [7:0] r_wd;
    logic [7:0] r_rd0, r_rd1;
    logic       r_cs_n, r_rw_n, r_ack0, r_ack1;

    logic w_req_any, w_pick1, w_we_eff, w_gnt_eff, w_capture;
    logic w_cs_n_next, w_rw_n_next, w_ack_next;

    always_comb begin
        w_req_any    = R0_REQ | R1_REQ;
        w_pick1      = R1_REQ & (~R0_REQ | ~r_gnt);
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_any) w_state_next = SETUP;
            end
            SETUP: begin
                w_state_next = STROBE;
                w_cnt_next   = STROBE_LOAD;
            end
            STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = RECOVER;
                    w_cnt_next   = RECOVER_LOAD;
                    w_capture    = ~r_we;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RECOVER: begin
                if (r_cnt == 4'd0) w_state_next = IDLE;
                else               w_cnt_next   = r_cnt - 4'd1;
            end
            default: w_state_next = IDLE;
        endcase

        // Strobes are registered, so they are decoded from the state being entered
        w_we_eff    = (r_state == IDLE) ? (w_pick1 ? R1_WE : R0_WE) : r_we;
        w_gnt_eff   = (r_state == IDLE) ? w_pick1 : r_gnt;
        w_cs_n_next = 1'b1;
        w_rw_n_next = 1'b1;
        w_ack_next  = 1'b0;
        case (w_state_next)
            SETUP:   w_cs_n_next = ~w_we_eff;
            STROBE: begin
                w_cs_n_next = 1'b0;
                w_rw_n_next = ~w_we_eff;
            end
            RECOVER: w_ack_next = (w_cnt_next == 4'd0);
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_cs_n  <= 1'b1;
            r_rw_n  <= 1'b1;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else if (CE) begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_cs_n  <= w_cs_n_next;
            r_rw_n  <= w_rw_n_next;
            r_ack0  <= w_ack_next & ~w_gnt_eff;
            r_ack1  <= w_ack_next & w_gnt_eff;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_gnt <= 1'b1;
            r_we  <= 1'b0;
            r_a   <= 6'd0;
            r_wd  <= 8'd0;
            r_rd0 <= 8'hFF;
            r_rd1 <= 8'hFF;
        end else if (CE) begin
            if (r_state == IDLE && w_req_any) begin
                r_gnt <= w_pick1;
                r_we  <= w_we_eff;
                r_a   <= w_pick1 ? R1_A : R0_A;
                r_wd  <= w_pick1 ? R1_WD : R0_WD;
            end
            if (w_capture) begin
                if (r_gnt) r_rd1 <= IO_DI;
                else       r_rd0 <= IO_DI;
            end
        end
    end

    assign R0_ACK  = r_ack0;
    assign R1_ACK  = r_ack1;
    assign R0_RD   = r_rd0;
    assign R1_RD   = r_rd1;
    assign IO_A    = r_a;
    assign IO_DO   = r_wd;
    assign IO_CS_N = r_cs_n;
    assign IO_RW_N = r_rw_n;
endmodule
